// File: rtl/cmos_capture_ctrl.sv
// Capture sequencer: arms on enable/single-shot, aligns to vsync, writes pixels into a double-buffered store.
// Latency: one cycle from frame_valid to wr_en/wr_addr/wr_data; frame status pulses one cycle after vs_rise.
// Backpressure: none; the camera cannot be stalled, so pixels are written or dropped as they arrive.
module cmos_capture_ctrl #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480,
    parameter int OFS_W = 19
) (
    input  logic             cam_pclk,
    input  logic             rst_n,
    input  logic             cap_en,
    input  logic             cap_single,
    input  logic             frame_vsync,
    input  logic             frame_href,
    input  logic             frame_valid,
    input  logic [15:0]      frame_data,
    input  logic             rd_active,
    input  logic             rd_bank,
    output logic             wr_en,
    output logic [OFS_W:0]   wr_addr,
    output logic [15:0]      wr_data,
    output logic             done_bank,
    output logic             frame_done,
    output logic             frame_err,
    output logic             frame_drop,
    output logic             busy,
    output logic [7:0]       frame_cnt
);

    // Counters saturate one past the active size so any overrun still reads as "not equal".
    localparam int COL_W  = $clog2(H_ACT + 2);
    localparam int LINE_W = $clog2(V_ACT + 2);
    localparam logic [COL_W-1:0]  COL_LIM  = COL_W'(H_ACT);
    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(H_ACT + 1);
    localparam logic [LINE_W-1:0] LINE_LIM = LINE_W'(V_ACT);
    localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(V_ACT + 1);
    localparam logic [OFS_W-1:0]  LINE_STEP = OFS_W'(H_ACT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_CAP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                single_q, single_d;
    logic                vs_q, href_q;
    logic [COL_W-1:0]    col_q, col_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [OFS_W-1:0]    base_q, base_d;
    logic                err_q, err_d;
    logic                wr_bank_q, wr_bank_d;
    logic                done_bank_q, done_bank_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                wr_en_q, wr_en_d;
    logic [OFS_W:0]      wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic                ferr_q, ferr_d;
    logic                drop_q, drop_d;

    logic                vs_rise, href_fall;
    logic                in_win;
    logic [COL_W-1:0]    col_inc;

    assign vs_rise   = frame_vsync & ~vs_q;
    assign href_fall = ~frame_href & href_q;
    assign in_win    = (col_q < COL_LIM) && (line_q < LINE_LIM);
    assign col_inc   = (col_q == COL_MAX) ? col_q : col_q + 1'b1;

    // FSM state register.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, pixel addressing and frame-close decisions.
    always_comb begin
        state_d     = state_q;
        single_d    = single_q;
        col_d       = col_q;
        line_d      = line_q;
        base_d      = base_q;
        err_d       = err_q;
        wr_bank_d   = wr_bank_q;
        done_bank_d = done_bank_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;
        ferr_d      = 1'b0;
        drop_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cap_en || cap_single) begin
                    state_d  = ST_ARM;
                    single_d = cap_single;
                end
            end
            ST_ARM: begin
                if (vs_rise) begin
                    state_d = ST_CAP;
                    col_d   = '0;
                    line_d  = '0;
                    base_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_CAP: begin
                if (vs_rise) begin
                    // Close the frame; a bad frame leaves the bank to be rewritten.
                    if ((line_q != LINE_LIM) || err_q) begin
                        ferr_d = 1'b1;
                    end else if (rd_active && (rd_bank == ~wr_bank_q)) begin
                        drop_d = 1'b1;
                    end else begin
                        done_d      = 1'b1;
                        done_bank_d = wr_bank_q;
                        wr_bank_d   = ~wr_bank_q;
                        cnt_d       = cnt_q + 8'd1;
                    end
                    col_d  = '0;
                    line_d = '0;
                    base_d = '0;
                    err_d  = 1'b0;
                    if (cap_en && !single_q) begin
                        state_d = ST_CAP;
                    end else begin
                        state_d  = ST_IDLE;
                        single_d = 1'b0;
                    end
                end else begin
                    if (frame_valid) begin
                        if (in_win) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = {wr_bank_q, base_q + OFS_W'(col_q)};
                            wr_data_d = frame_data;
                        end else begin
                            err_d = 1'b1;
                        end
                        col_d = col_inc;
                    end
                    // Line length is judged including a pixel landing on the same cycle.
                    if (href_fall) begin
                        if (col_d != COL_LIM) begin
                            err_d = 1'b1;
                        end
                        line_d = (line_q == LINE_MAX) ? line_q : line_q + 1'b1;
                        base_d = base_q + LINE_STEP;
                        col_d  = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers; edge detectors sample the raw sync inputs.
    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            single_q    <= 1'b0;
            vs_q        <= 1'b0;
            href_q      <= 1'b0;
            col_q       <= '0;
            line_q      <= '0;
            base_q      <= '0;
            err_q       <= 1'b0;
            wr_bank_q   <= 1'b0;
            done_bank_q <= 1'b0;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            single_q    <= single_d;
            vs_q        <= frame_vsync;
            href_q      <= frame_href;
            col_q       <= col_d;
            line_q      <= line_d;
            base_q      <= base_d;
            err_q       <= err_d;
            wr_bank_q   <= wr_bank_d;
            done_bank_q <= done_bank_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
            ferr_q      <= ferr_d;
            drop_q      <= drop_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign done_bank  = done_bank_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;
    assign frame_drop = drop_q;
    assign frame_cnt  = cnt_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Bench for cmos_capture_ctrl with a tiny 4x2 frame geometry.
// Directed scenarios plus a randomized continuous-capture run against a frame-level reference model.
// Writes and status pulses are collected by a monitor and compared at each frame boundary.
module tb_cmos_capture_ctrl;

    localparam int H = 4;
    localparam int V = 2;
    localparam int OW = 3;

    logic          cam_pclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap_en = 1'b0;
    logic          cap_single = 1'b0;
    logic          frame_vsync = 1'b0;
    logic          frame_href = 1'b0;
    logic          frame_valid = 1'b0;
    logic [15:0]   frame_data = '0;
    logic          rd_active = 1'b0;
    logic          rd_bank = 1'b0;
    logic          wr_en;
    logic [OW:0]   wr_addr;
    logic [15:0]   wr_data;
    logic          done_bank;
    logic          frame_done;
    logic          frame_err;
    logic          frame_drop;
    logic          busy;
    logic [7:0]    frame_cnt;

    cmos_capture_ctrl #(.H_ACT(H), .V_ACT(V), .OFS_W(OW)) dut (
        .cam_pclk    (cam_pclk),
        .rst_n       (rst_n),
        .cap_en      (cap_en),
        .cap_single  (cap_single),
        .frame_vsync (frame_vsync),
        .frame_href  (frame_href),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .rd_active   (rd_active),
        .rd_bank     (rd_bank),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done_bank   (done_bank),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .frame_drop  (frame_drop),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always #5 cam_pclk = ~cam_pclk;

    int checks = 0;
    int errors = 0;

    // Observed and expected traffic: writes are {addr, data}, events are {done,err,drop,done_bank,frame_cnt}.
    logic [19:0] obs_w[$];
    logic [19:0] exp_w[$];
    logic [11:0] obs_ev[$];
    logic [11:0] exp_ev[$];

    // Reference model: capture mode is 0 idle, 1 waiting for a frame start, 2 capturing.
    int          m_mode = 0;
    bit          m_single = 0;
    bit          m_wb = 0;
    bit          m_db = 0;
    int          m_cnt = 0;
    int          m_line = 0;
    int          m_lines_ok = 1;
    bit          m_err = 0;

    always @(negedge cam_pclk) begin
        if (rst_n) begin
            if (wr_en) obs_w.push_back({wr_addr, wr_data});
            if (frame_done || frame_err || frame_drop)
                obs_ev.push_back({frame_done, frame_err, frame_drop, done_bank, frame_cnt});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge cam_pclk);
    endtask

    task automatic model_reset();
        m_mode = 0; m_single = 0; m_wb = 0; m_db = 0; m_cnt = 0;
        m_line = 0; m_err = 0;
        exp_w.delete(); exp_ev.delete(); obs_w.delete(); obs_ev.delete();
    endtask

    task automatic do_reset();
        @(negedge cam_pclk);
        rst_n = 1'b0;
        cap_en = 0; cap_single = 0; frame_vsync = 0; frame_href = 0; frame_valid = 0;
        rd_active = 0; rd_bank = 0;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(1);
    endtask

    task automatic set_en(input bit v);
        @(negedge cam_pclk);
        cap_en = v;
        if (v && m_mode == 0) begin m_mode = 1; m_single = 0; end
        tick(2);
    endtask

    task automatic single_pulse();
        @(negedge cam_pclk);
        cap_single = 1'b1;
        @(negedge cam_pclk);
        cap_single = 1'b0;
        if (m_mode == 0) begin m_mode = 1; m_single = 1; end
        tick(1);
    endtask

    // Frame boundary; optionally a stray pixel coincides with it and must be ignored.
    task automatic vsync_pulse(input bit with_px);
        @(negedge cam_pclk);
        frame_vsync = 1'b1;
        frame_valid = with_px;
        frame_data  = 16'($urandom);
        @(negedge cam_pclk);
        frame_vsync = 1'b0;
        frame_valid = 1'b0;
        if (m_mode == 2) begin
            if (m_err || m_line != V) begin
                exp_ev.push_back({3'b010, m_db, 8'(m_cnt)});
            end else if (rd_active && rd_bank != m_wb) begin
                exp_ev.push_back({3'b001, m_db, 8'(m_cnt)});
            end else begin
                m_db = m_wb;
                m_wb = ~m_wb;
                m_cnt = (m_cnt + 1) % 256;
                exp_ev.push_back({3'b100, m_db, 8'(m_cnt)});
            end
            if (cap_en && !m_single) begin
                m_line = 0; m_err = 0;
            end else begin
                m_mode = 0; m_single = 0;
            end
        end else if (m_mode == 1) begin
            m_mode = 2; m_line = 0; m_err = 0;
        end
        if (m_mode == 0 && cap_en) begin m_mode = 1; m_single = 0; end
        tick(2);
    endtask

    // One line of n pixels; the model stores what lands inside the 4x2 window.
    task automatic send_line(input int n);
        logic [15:0] d;
        logic [3:0]  a;
        for (int j = 0; j < n; j++) begin
            @(negedge cam_pclk);
            d = 16'($urandom);
            frame_href  = 1'b1;
            frame_valid = 1'b1;
            frame_data  = d;
            if (m_mode == 2) begin
                if (j < H && m_line < V) begin
                    a = 4'((int'(m_wb) << OW) + m_line * H + j);
                    exp_w.push_back({a, d});
                end else begin
                    m_err = 1;
                end
            end
        end
        @(negedge cam_pclk);
        frame_href  = 1'b0;
        frame_valid = 1'b0;
        if (m_mode == 2) begin
            if (n != H) m_err = 1;
            m_line++;
        end
        tick(1);
    endtask

    task automatic send_frame2(input int a, input int b);
        send_line(a);
        send_line(b);
    endtask

    task automatic check_all(input string tag);
        #1;
        chk({tag, " nwr"}, obs_w.size(), exp_w.size());
        for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
            chk({tag, " wr"}, 32'(obs_w[i]), 32'(exp_w[i]));
        chk({tag, " nev"}, obs_ev.size(), exp_ev.size());
        for (int i = 0; i < obs_ev.size() && i < exp_ev.size(); i++)
            chk({tag, " ev"}, 32'(obs_ev[i]), 32'(exp_ev[i]));
        chk({tag, " busy"}, 32'(busy), 32'(m_mode != 0));
        chk({tag, " done_bank"}, 32'(done_bank), 32'(m_db));
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
        obs_w.delete(); exp_w.delete(); obs_ev.delete(); exp_ev.delete();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " wr_en"}, 32'(wr_en), 0);
        chk({tag, " wr_addr"}, 32'(wr_addr), 0);
        chk({tag, " wr_data"}, 32'(wr_data), 0);
        chk({tag, " pulses"}, 32'({frame_done, frame_err, frame_drop}), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done_bank"}, 32'(done_bank), 0);
        chk({tag, " frame_cnt"}, 32'(frame_cnt), 0);
    endtask

    initial begin
        // Reset state.
        #12;
        check_zero("reset");
        do_reset();
        check_all("post_reset");

        // Single shot: one frame captured into bank 0, the following frame ignored.
        single_pulse();
        vsync_pulse(0);
        check_all("t1_open");
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("t1_close");
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("t1_ignored");

        // Continuous capture, banks alternate; dropping enable still finishes the open frame.
        do_reset();
        set_en(1);
        vsync_pulse(0);
        for (int f = 0; f < 3; f++) begin
            send_frame2(4, 4);
            vsync_pulse(0);
            check_all("t2_frame");
        end
        set_en(0);
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("t2_last");

        // Short line: error, bank kept, count kept; next good frame reuses bank 0.
        do_reset();
        single_pulse();
        vsync_pulse(0);
        send_frame2(4, 3);
        vsync_pulse(0);
        check_all("t3_short");
        single_pulse();
        vsync_pulse(0);
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("t3_after");

        // Reader holds the other bank: good frame dropped, then rewritten at addr 0..7.
        do_reset();
        rd_active = 1'b1;
        rd_bank = 1'b1;
        single_pulse();
        vsync_pulse(0);
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("t4_drop");
        rd_active = 1'b0;
        single_pulse();
        vsync_pulse(0);
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("t4_after");

        // Overlong line: fifth pixel not written, frame errors.
        do_reset();
        single_pulse();
        vsync_pulse(0);
        send_frame2(5, 4);
        vsync_pulse(0);
        check_all("t5_long");

        // Reset mid-capture: outputs clear at once, no status pulse, re-arm waits for vsync.
        do_reset();
        set_en(1);
        vsync_pulse(0);
        chk("t6_busy_before", 32'(busy), 1);
        for (int j = 0; j < 3; j++) begin
            @(negedge cam_pclk);
            frame_href = 1'b1;
            frame_valid = 1'b1;
            frame_data = 16'($urandom);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_reset");
        frame_href = 1'b0; frame_valid = 1'b0; cap_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(3);
        check_all("t6_quiet");
        single_pulse();
        send_line(4);
        check_all("t6_armed");
        vsync_pulse(0);
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("t6_frame");

        // Randomized continuous run: random geometry, reader state and stray pixels.
        do_reset();
        set_en(1);
        vsync_pulse(0);
        for (int f = 0; f < 24; f++) begin
            int nl;
            int pick;
            nl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : V;
            for (int l = 0; l < nl; l++) begin
                pick = int'($urandom_range(0, 5));
                send_line(pick == 0 ? 3 : (pick == 1 ? 5 : H));
            end
            if ($urandom_range(0, 4) == 0) single_pulse();
            rd_active = 1'($urandom);
            rd_bank = 1'($urandom);
            vsync_pulse(1'($urandom));
            check_all("rand_frame");
        end
        set_en(0);
        send_frame2(4, 4);
        vsync_pulse(0);
        check_all("rand_last");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
